// File: rtl/mem_stage_ls.sv
// mem_stage_ls: RV32I memory-access stage with sized loads/stores, misalignment
// suppression, a configurable data-memory wait count with stall handshake, the
// branch-decision AND and the MEM/WB pipeline register.
module mem_stage_ls #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      wb_ctl,
    input  logic            branch,
    input  logic            memread,
    input  logic            memwrite,
    input  logic            zero,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      write_reg,
    output logic            pcsrc,
    output logic            stall,
    output logic            wb_regwrite,
    output logic            wb_memtoreg,
    output logic [XLEN-1:0] wb_read_data,
    output logic [XLEN-1:0] wb_alu_result,
    output logic [4:0]      wb_write_reg,
    output logic            wb_misaligned
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t          state, state_nx;
    logic [3:0]      wait_cnt, wait_cnt_nx;
    size_t           size;
    logic            access;
    logic            misaligned;
    logic            aligned_access;
    logic            complete;
    logic            mem_we;
    logic [3:0]      byte_en;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [XLEN-1:0] ld_data;
    logic [AW-1:0]   widx;
    logic [1:0]      lane;

    logic [XLEN-1:0] mem [DEPTH];

    assign pcsrc  = branch & zero;
    assign widx   = alu_result[AW+1:2];
    assign lane   = alu_result[1:0];
    assign access = memread | memwrite;

    // Access size: a simultaneous read+write is a store, so the store decode wins.
    always_comb begin
        size = SZ_W;
        if (memwrite) begin
            case (funct3[1:0])
                2'b00:   size = SZ_B;
                2'b01:   size = SZ_H;
                default: size = SZ_W;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b100: size = SZ_B;
                3'b001, 3'b101: size = SZ_H;
                default:        size = SZ_W;
            endcase
        end
    end

    assign misaligned     = access & (((size == SZ_H) & lane[0]) |
                                      ((size == SZ_W) & (lane != 2'b00)));
    assign aligned_access = access & ~misaligned;

    // Wait-state controller: stalls an aligned access for LATENCY cycles.
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        stall       = 1'b0;
        complete    = 1'b0;
        case (state)
            IDLE: begin
                if (aligned_access && (LATENCY != 0)) begin
                    stall       = 1'b1;
                    wait_cnt_nx = LAT_M1;
                    state_nx    = BUSY;
                end else begin
                    complete = 1'b1;
                end
            end
            BUSY: begin
                if (wait_cnt != 4'd0) begin
                    stall       = 1'b1;
                    wait_cnt_nx = wait_cnt - 4'd1;
                end else begin
                    complete = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx    = IDLE;
                wait_cnt_nx = 4'd0;
            end
        endcase
    end

    // FSM state and wait counter.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    // Store lane enables and lane-replicated write data.
    always_comb begin
        byte_en = 4'b0000;
        wdata   = store_data;
        case (size)
            SZ_B: begin
                byte_en = 4'b0001 << lane;
                wdata   = {4{store_data[7:0]}};
            end
            SZ_H: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{store_data[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wdata   = store_data;
            end
        endcase
    end

    assign mem_we = complete & memwrite & ~misaligned;

    // Byte-lane data memory; a reset clears the contents.
    // NOTE: this memory is reset on purpose (contents must read 0 after reset), so it maps to flops, not a RAM macro.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Load lane select and sign/zero extension; zero for stores and misaligned loads.
    always_comb begin
        rd_word = mem[widx];
        rd_byte = 8'h00;
        case (lane)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        ld_data = '0;
        if (memread && !memwrite && !misaligned) begin
            case (size)
                SZ_B:    ld_data = funct3[2] ? {{(XLEN-8){1'b0}}, rd_byte}
                                             : {{(XLEN-8){rd_byte[7]}}, rd_byte};
                SZ_H:    ld_data = funct3[2] ? {{(XLEN-16){1'b0}}, rd_half}
                                             : {{(XLEN-16){rd_half[15]}}, rd_half};
                default: ld_data = rd_word;
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, capture on completion.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_regwrite   <= 1'b0;
            wb_memtoreg   <= 1'b0;
            wb_read_data  <= '0;
            wb_alu_result <= '0;
            wb_write_reg  <= 5'd0;
            wb_misaligned <= 1'b0;
        end else if (!complete) begin
            wb_regwrite   <= 1'b0;
            wb_memtoreg   <= 1'b0;
            wb_read_data  <= '0;
            wb_alu_result <= '0;
            wb_write_reg  <= 5'd0;
            wb_misaligned <= 1'b0;
        end else begin
            wb_regwrite   <= wb_ctl[1] & ~misaligned;
            wb_memtoreg   <= wb_ctl[0];
            wb_read_data  <= ld_data;
            wb_alu_result <= alu_result;
            wb_write_reg  <= write_reg;
            wb_misaligned <= misaligned;
        end
    end

endmodule

// File: tb/tb_mem_stage_ls.sv
// tb_mem_stage_ls: three instances (LATENCY 0, 2, 3) checked every cycle against
// a transaction-level byte-array model, plus directed literal expectations.
module tb_mem_stage_ls;

    localparam int N     = 3;
    localparam int BYTES = 1024;  // DEPTH 256 words * 4

    typedef struct packed {
        logic [1:0]  wb_ctl;
        logic        branch;
        logic        memread;
        logic        memwrite;
        logic        zero;
        logic [2:0]  funct3;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  write_reg;
    } op_t;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  write_reg;
        logic        misaligned;
    } wb_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n       [N];
    logic [1:0]  wb_ctl        [N];
    logic        branch        [N];
    logic        memread       [N];
    logic        memwrite      [N];
    logic        zero          [N];
    logic [2:0]  funct3        [N];
    logic [31:0] alu_result    [N];
    logic [31:0] store_data    [N];
    logic [4:0]  write_reg     [N];
    logic        pcsrc         [N];
    logic        stall         [N];
    logic        wb_regwrite   [N];
    logic        wb_memtoreg   [N];
    logic [31:0] wb_read_data  [N];
    logic [31:0] wb_alu_result [N];
    logic [4:0]  wb_write_reg  [N];
    logic        wb_misaligned [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_stage_ls #(
            .XLEN(32), .DEPTH(256), .LATENCY(g == 0 ? 0 : g + 1)
        ) u_dut (
            .clock(clock), .reset(reset_n[g]),
            .wb_ctl(wb_ctl[g]), .branch(branch[g]), .memread(memread[g]),
            .memwrite(memwrite[g]), .zero(zero[g]), .funct3(funct3[g]),
            .alu_result(alu_result[g]), .store_data(store_data[g]),
            .write_reg(write_reg[g]), .pcsrc(pcsrc[g]), .stall(stall[g]),
            .wb_regwrite(wb_regwrite[g]), .wb_memtoreg(wb_memtoreg[g]),
            .wb_read_data(wb_read_data[g]), .wb_alu_result(wb_alu_result[g]),
            .wb_write_reg(wb_write_reg[g]), .wb_misaligned(wb_misaligned[g])
        );
    end

    int   checks = 0;
    int   errors = 0;
    logic chk_en     [N];
    logic exp_stall  [N];
    wb_t  exp_wb     [N];
    logic exp_rd_chk [N];
    logic [7:0] mref [N][BYTES];

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : i + 1;
    endfunction

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[u%0d] got %h expected %h at %0t", name, i, act, exp, $time);
        end
    endtask

    function automatic op_t nop_op();
        op_t o = '0;
        return o;
    endfunction

    function automatic op_t mk_ld(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd);
        op_t o = '0;
        o.wb_ctl = 2'b11; o.memread = 1'b1; o.funct3 = f3; o.alu_result = a; o.write_reg = rd;
        return o;
    endfunction

    function automatic op_t mk_st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        op_t o = '0;
        o.memwrite = 1'b1; o.funct3 = f3; o.alu_result = a; o.store_data = d;
        return o;
    endfunction

    function automatic op_t mk_alu(input logic [31:0] v, input logic [4:0] rd);
        op_t o = '0;
        o.wb_ctl = 2'b10; o.alu_result = v; o.write_reg = rd;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        logic [31:0] a;
        o.wb_ctl     = 2'($urandom);
        o.branch     = 1'($urandom);
        o.zero       = 1'($urandom);
        o.memread    = 1'($urandom);
        o.memwrite   = ($urandom_range(0, 2) == 0);
        o.funct3     = 3'($urandom);
        o.store_data = $urandom;
        o.write_reg  = 5'($urandom);
        a = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
        if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_FC00);
        o.alu_result = a;
        return o;
    endfunction

    // Size in bytes of an access, from the load or store encoding.
    function automatic int nbytes_of(input op_t o);
        if (o.memwrite) return (o.funct3[1:0] == 2'b00) ? 1 : (o.funct3[1:0] == 2'b01) ? 2 : 4;
        if (o.funct3 == 3'b000 || o.funct3 == 3'b100) return 1;
        if (o.funct3 == 3'b001 || o.funct3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic bit is_mis(input op_t o);
        return (o.memread || o.memwrite) && ((o.alu_result % nbytes_of(o)) != 0);
    endfunction

    // Reference: apply one completed instruction to the byte-array memory and
    // return what the MEM/WB register must hold afterwards.
    task automatic model_op(input int i, input op_t o, output wb_t r);
        int          nb;
        int          base;
        bit          mis;
        logic [31:0] v;
        nb   = nbytes_of(o);
        mis  = is_mis(o);
        base = int'(o.alu_result % BYTES);
        v    = 32'h0;
        if (o.memread && !o.memwrite && !mis) begin
            for (int b = 0; b < nb; b++) v[8*b +: 8] = mref[i][(base + b) % BYTES];
            if (nb == 1 && o.funct3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
            if (nb == 2 && o.funct3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
        end
        if (o.memwrite && !mis) begin
            for (int b = 0; b < nb; b++) mref[i][(base + b) % BYTES] = o.store_data[8*b +: 8];
        end
        r.regwrite   = o.wb_ctl[1] & !mis;
        r.memtoreg   = o.wb_ctl[0];
        r.read_data  = v;
        r.alu_result = o.alu_result;
        r.write_reg  = o.write_reg;
        r.misaligned = mis;
    endtask

    task automatic drive(input int i, input op_t o);
        wb_ctl[i]     = o.wb_ctl;
        branch[i]     = o.branch;
        memread[i]    = o.memread;
        memwrite[i]   = o.memwrite;
        zero[i]       = o.zero;
        funct3[i]     = o.funct3;
        alu_result[i] = o.alu_result;
        store_data[i] = o.store_data;
        write_reg[i]  = o.write_reg;
    endtask

    // Present one instruction and hold it until it completes. An aligned memory
    // access waits LATENCY cycles with bubbles; everything else completes at once.
    task automatic do_op(input int i, input op_t o, output int stall_seen, output logic pc_stall);
        wb_t r;
        int  n;
        drive(i, o);
        n = ((o.memread || o.memwrite) && !is_mis(o)) ? lat_of(i) : 0;
        stall_seen = 0;
        pc_stall   = 1'b0;
        for (int k = 0; k < n; k++) begin
            exp_stall[i] = 1'b1;
            @(negedge clock);
            if (stall[i]) begin
                stall_seen++;
                pc_stall = pcsrc[i];
            end
            @(posedge clock); #1;
            exp_wb[i]     = '0;
            exp_rd_chk[i] = 1'b1;
        end
        exp_stall[i] = 1'b0;
        @(negedge clock);
        if (stall[i]) stall_seen++;
        @(posedge clock); #1;
        model_op(i, o, r);
        exp_wb[i]     = r;
        exp_rd_chk[i] = o.memread;
    endtask

    task automatic op0(input int i, input op_t o);
        int   s;
        logic p;
        do_op(i, o, s, p);
    endtask

    // Per-cycle comparison of every enabled instance against the model.
    always @(negedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (chk_en[i]) begin
                check("stall", i, stall[i], exp_stall[i]);
                check("pcsrc", i, pcsrc[i], branch[i] & zero[i]);
                check("wb_regwrite", i, wb_regwrite[i], exp_wb[i].regwrite);
                check("wb_memtoreg", i, wb_memtoreg[i], exp_wb[i].memtoreg);
                check("wb_alu_result", i, wb_alu_result[i], exp_wb[i].alu_result);
                check("wb_write_reg", i, wb_write_reg[i], exp_wb[i].write_reg);
                check("wb_misaligned", i, wb_misaligned[i], exp_wb[i].misaligned);
                if (exp_rd_chk[i]) check("wb_read_data", i, wb_read_data[i], exp_wb[i].read_data);
            end
        end
    end

    task automatic check_wb_zero(input string tag, input int i);
        check({tag, "_regwrite"}, i, wb_regwrite[i], 1'b0);
        check({tag, "_memtoreg"}, i, wb_memtoreg[i], 1'b0);
        check({tag, "_read_data"}, i, wb_read_data[i], 32'h0);
        check({tag, "_alu_result"}, i, wb_alu_result[i], 32'h0);
        check({tag, "_write_reg"}, i, wb_write_reg[i], 5'd0);
        check({tag, "_misaligned"}, i, wb_misaligned[i], 1'b0);
    endtask

    initial begin
        int   seen;
        logic pcs;
        op_t  o;

        for (int i = 0; i < N; i++) begin
            chk_en[i]     = 1'b0;
            reset_n[i]    = 1'b0;
            exp_stall[i]  = 1'b0;
            exp_wb[i]     = '0;
            exp_rd_chk[i] = 1'b1;
            drive(i, nop_op());
            for (int b = 0; b < BYTES; b++) mref[i][b] = 8'h00;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            check_wb_zero("reset", i);
            check("reset_stall", i, stall[i], 1'b0);
            reset_n[i] = 1'b1;
            chk_en[i]  = 1'b1;
        end
        @(posedge clock); #1;

        // Sized stores and loads, LATENCY=0.
        op0(0, mk_st(3'b010, 32'h20, 32'h80FF7F01));
        op0(0, mk_ld(3'b000, 32'h20, 5'd1));
        check("lb_20", 0, wb_read_data[0], 32'h00000001);
        check("lb_20_regwrite", 0, wb_regwrite[0], 1'b1);
        op0(0, mk_ld(3'b000, 32'h23, 5'd2));
        check("lb_23", 0, wb_read_data[0], 32'hFFFFFF80);
        op0(0, mk_ld(3'b100, 32'h23, 5'd3));
        check("lbu_23", 0, wb_read_data[0], 32'h00000080);
        op0(0, mk_ld(3'b001, 32'h22, 5'd4));
        check("lh_22", 0, wb_read_data[0], 32'hFFFF80FF);
        op0(0, mk_ld(3'b101, 32'h22, 5'd5));
        check("lhu_22", 0, wb_read_data[0], 32'h000080FF);
        op0(0, mk_st(3'b000, 32'h21, 32'h000000AA));
        op0(0, mk_ld(3'b010, 32'h20, 5'd6));
        check("lw_20_after_sb", 0, wb_read_data[0], 32'h80FFAA01);

        // Misaligned accesses are suppressed and flagged for one cycle.
        op0(0, mk_ld(3'b010, 32'h22, 5'd7));
        check("lw_22_misaligned", 0, wb_misaligned[0], 1'b1);
        check("lw_22_regwrite", 0, wb_regwrite[0], 1'b0);
        check("lw_22_data", 0, wb_read_data[0], 32'h0);
        op0(0, mk_st(3'b001, 32'h21, 32'h0000BEEF));
        check("sh_21_misaligned", 0, wb_misaligned[0], 1'b1);
        op0(0, nop_op());
        check("misaligned_cleared", 0, wb_misaligned[0], 1'b0);
        op0(0, mk_ld(3'b010, 32'h20, 5'd8));
        check("lw_20_unchanged", 0, wb_read_data[0], 32'h80FFAA01);

        // Address wrap modulo DEPTH*4.
        op0(0, mk_st(3'b010, 32'h400, 32'h12345678));
        op0(0, mk_ld(3'b010, 32'h000, 5'd9));
        check("lw_wrap", 0, wb_read_data[0], 32'h12345678);
        op0(0, nop_op());

        // Multi-cycle access, LATENCY=2, with a taken branch during the stall.
        do_op(1, mk_st(3'b010, 32'h8, 32'hCAFEF00D), seen, pcs);
        check("sw_lat2_stall_cycles", 1, seen, 2);
        o = mk_ld(3'b010, 32'h8, 5'd9);
        o.branch = 1'b1;
        o.zero   = 1'b1;
        do_op(1, o, seen, pcs);
        check("lw_lat2_stall_cycles", 1, seen, 2);
        check("pcsrc_in_stall", 1, pcs, 1'b1);
        check("lw_lat2_data", 1, wb_read_data[1], 32'hCAFEF00D);
        check("lw_lat2_regwrite", 1, wb_regwrite[1], 1'b1);
        do_op(1, mk_alu(32'h55, 5'd3), seen, pcs);
        check("alu_after_load_stall", 1, seen, 0);
        check("alu_after_load_value", 1, wb_alu_result[1], 32'h55);
        op0(1, nop_op());

        // Reset mid-stall (LATENCY=3): the in-flight store never commits.
        drive(2, mk_st(3'b010, 32'h10, 32'hDEADBEEF));
        exp_stall[2] = 1'b1;
        @(posedge clock); #1;
        exp_wb[2]     = '0;
        exp_rd_chk[2] = 1'b1;
        chk_en[2]     = 1'b0;
        reset_n[2]    = 1'b0;
        #1;
        check_wb_zero("in_reset", 2);
        repeat (3) @(posedge clock);
        #1;
        drive(2, nop_op());
        reset_n[2] = 1'b1;
        #1;
        check("stall_after_reset", 2, stall[2], 1'b0);
        check_wb_zero("after_reset", 2);
        exp_stall[2] = 1'b0;
        chk_en[2]    = 1'b1;
        op0(2, mk_ld(3'b010, 32'h10, 5'd4));
        check("lw_10_after_reset", 2, wb_read_data[2], 32'h0);
        op0(2, nop_op());

        // Randomised traffic on every instance.
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < ((i == 0) ? 200 : 70); k++) op0(i, rand_op());
            op0(i, nop_op());
        end

        repeat (3) @(posedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
